hex_update_arbiter: RTL and testbench
=====================================

Name: hex_update_arbiter

Overview:
- Shares one combinational 4-bit-to-7-segment decoder (active-low outputs, bit 0 = segment a … bit 6 = segment g) among NUM_DIGITS display slots.
- Requesters post a nibble plus a request. The arbiter grants slots round-robin, drives the shared decoder and latches its segment pattern into a per-slot register that feeds HEX pins.
- A periodic refresh sweep re-decodes every slot so stale patterns self-heal.

Parameters:
- NUM_DIGITS, 6, number of display slots (2..8).
- IDLE_REFRESH, 1024, idle cycles before an automatic refresh sweep (≥4).

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- req  input  NUM_DIGITS  per-slot update request, level, held until ack.
- nibble  input  4*NUM_DIGITS  slot i value at [4i+3:4i].
- blank  input  NUM_DIGITS  slot shows all segments off when serviced with blank=1.
- ack  output  NUM_DIGITS  one-cycle pulse when slot's external request is serviced.
- dec_val  output  4  value to shared decoder.
- dec_seg  input  7  shared decoder result, combinational from dec_val, active-low.
- hex_out  output  7*NUM_DIGITS  latched active-low pattern, slot i at [7i+6:7i].
- busy  output  1  high while state is LATCH.

Behaviour:
- Reset (async, resetn=0) sets these values:
  - hex_out all 1s (display dark).
  - ack 0, dec_val 0, busy 0.
  - state IDLE, rr pointer 0, refresh counter 0, refresh mask 0.
- The effective request vector is eff = (req & ~ack) | refresh_mask. A slot whose ack is high this cycle is masked, so there is no double service.
- IDLE state:
  - If eff≠0, select the first set bit of eff at or after the pointer, wrapping modulo NUM_DIGITS. This is grant g.
  - On the next edge: dec_val<=nibble[g], blank_r<=blank[g], ext_r<=req[g] & ~ack[g], state<=LATCH.
  - The nibble and blank values of slot g are sampled only at this edge.
- LATCH state:
  - busy=1.
  - On the next edge: hex_out[g] <= blank_r ? 7'h7F : dec_seg.
  - ack[g]<=ext_r; refresh_mask[g]<=0; pointer<=(g+1) mod NUM_DIGITS; state<=IDLE.
- Latency: req sampled at edge t gives dec_val valid after t and hex_out/ack updated at edge t+1. Throughput is one slot per 2 cycles.
- Requests arriving while in LATCH wait. No request is lost while held.
- Refresh counter:
  - Increments each cycle in IDLE with eff=0. Clears otherwise.
  - When it reaches IDLE_REFRESH-1, refresh_mask<=all 1s and the counter clears.
  - Refresh-only services produce no ack.
  - If an external req coincides with a refresh service of the same slot, ack is pulsed.
- A req dropped before grant is simply not serviced. This is legal.
- Reset asserted mid-LATCH aborts the write: hex_out goes all 1s and no ack is issued.
- A decoder output for an unused pointer value cannot occur, because the pointer wraps strictly below NUM_DIGITS.

Optional Feature:
- Macro HEX_UPDATE_ARBITER_LAMP_TEST_EN.
- When defined:
  - Adds input lamp_test (1 bit).
  - While lamp_test=1, hex_out is forced combinationally to all 0s (every segment lit).
  - Stored slot registers, FSM, acks and refresh continue unchanged.
  - On deassert, the stored patterns reappear the same cycle.
- When undefined: no port, no logic, hex_out is the stored registers directly.

Test Plan:
- Reset: hold resetn=0 with random inputs → hex_out all 1s, ack=0, busy=0. Release → hex_out remains all 1s with no requests.
- Single update: req[2]=1, nibble[2]=4'h5 →
  - dec_val=5 one cycle after the sampling edge.
  - Next edge: hex_out[2]=7'b0010010 and ack[2] is a one-cycle pulse.
  - Requester drops req; no second ack.
- Round-robin full sweep: pointer 0, all six req with nibbles 0..5 → acks on slots 0,1,2,3,4,5 every second cycle. hex_out = 1000000, 1111001, 0100100, 0110000, 0011001, 0010010.
- Fairness: after servicing slot 2, assert req[0] and req[4] together → slot 4 acked first, slot 0 two cycles later.
- Blank: req[1], blank[1]=1, nibble[1]=8 → hex_out[1]=7'h7F, ack[1] pulses.
- Refresh: IDLE_REFRESH=8, no requests. Change nibble[0] to 0 without req → within 8+12 cycles hex_out[0]=7'b1000000 and ack stays 0. Separately, assert resetn=0 during LATCH → hex_out all 1s and no ack.

Source files
------------

// File: rtl/hex_update_arbiter.sv
// Round-robin arbiter sharing one external 7-segment decoder among NUM_DIGITS latched slots.
// Optional lamp test (all segments lit) enabled by defining HEX_UPDATE_ARBITER_LAMP_TEST_EN.
//
// state | meaning
// IDLE  | waiting for an external request or pending refresh; picks the next grant
// LATCH | dec_val is stable for the granted slot; dec_seg is captured on the next edge
module hex_update_arbiter #(
  parameter int NUM_DIGITS   = 6,
  parameter int IDLE_REFRESH = 1024
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NUM_DIGITS-1:0]     req,
  input  logic [4*NUM_DIGITS-1:0]   nibble,
  input  logic [NUM_DIGITS-1:0]     blank,
`ifdef HEX_UPDATE_ARBITER_LAMP_TEST_EN
  input  logic                      lamp_test,
`endif
  output logic [NUM_DIGITS-1:0]     ack,
  output logic [3:0]                dec_val,
  input  logic [6:0]                dec_seg,
  output logic [7*NUM_DIGITS-1:0]   hex_out,
  output logic                      busy
);

  localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(IDLE_REFRESH);
  localparam logic [CW-1:0] CNT_LAST = CW'(IDLE_REFRESH - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_DIGITS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    LATCH = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [PW-1:0]             ptr_q;
  logic [PW-1:0]             g_q;
  logic [PW-1:0]             grant;
  logic                      found;
  logic [NUM_DIGITS-1:0]     eff;
  logic [NUM_DIGITS-1:0]     mask_q;
  logic [NUM_DIGITS-1:0]     ack_q;
  logic [CW-1:0]             cnt_q;
  logic [3:0]                dec_val_q;
  logic                      blank_r;
  logic                      ext_r;
  logic [7*NUM_DIGITS-1:0]   hex_q;

  // A slot acked this cycle still has req high; masking it avoids a repeat service.
  assign eff = (req & ~ack_q) | mask_q;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!found && eff[(int'(ptr_q) + k) % NUM_DIGITS]) begin
        grant = PW'((int'(ptr_q) + k) % NUM_DIGITS);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr_q     <= '0;
      g_q       <= '0;
      mask_q    <= '0;
      ack_q     <= '0;
      cnt_q     <= '0;
      dec_val_q <= 4'h0;
      blank_r   <= 1'b0;
      ext_r     <= 1'b0;
      hex_q     <= '1;
    end else begin
      ack_q <= '0;
      if (state_q == IDLE && found) begin
        g_q       <= grant;
        dec_val_q <= nibble[4*int'(grant) +: 4];
        blank_r   <= blank[grant];
        ext_r     <= req[grant] & ~ack_q[grant];
      end
      if (state_q == LATCH) begin
        hex_q[7*int'(g_q) +: 7] <= blank_r ? 7'h7F : dec_seg;
        ack_q[g_q]              <= ext_r;
        mask_q[g_q]             <= 1'b0;
        ptr_q                   <= (g_q == PTR_LAST) ? '0 : g_q + PW'(1);
      end
      // Idle timer only runs while there is nothing at all to service.
      if (state_q == IDLE && !found) begin
        if (cnt_q == CNT_LAST) begin
          cnt_q  <= '0;
          mask_q <= '1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign ack     = ack_q;
  assign dec_val = dec_val_q;
  assign busy    = (state_q == LATCH);

`ifdef HEX_UPDATE_ARBITER_LAMP_TEST_EN
  assign hex_out = lamp_test ? '0 : hex_q;
`else
  assign hex_out = hex_q;
`endif

endmodule

// File: tb/tb_hex_update_arbiter.sv
// Directed bench for hex_update_arbiter: reset, single update, round-robin sweep,
// fairness, blanking, idle refresh and reset during LATCH.
module tb_hex_update_arbiter;

  localparam int N = 6;

  logic            clock;
  logic            resetn;
  logic [N-1:0]    req;
  logic [4*N-1:0]  nibble;
  logic [N-1:0]    blank;
  logic [N-1:0]    ack;
  logic [3:0]      dec_val;
  logic [6:0]      dec_seg;
  logic [7*N-1:0]  hex_out;
  logic            busy;
`ifdef HEX_UPDATE_ARBITER_LAMP_TEST_EN
  logic            lamp_test;
  initial lamp_test = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  hex_update_arbiter #(.NUM_DIGITS(N), .IDLE_REFRESH(8)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .req     (req),
    .nibble  (nibble),
    .blank   (blank),
`ifdef HEX_UPDATE_ARBITER_LAMP_TEST_EN
    .lamp_test (lamp_test),
`endif
    .ack     (ack),
    .dec_val (dec_val),
    .dec_seg (dec_seg),
    .hex_out (hex_out),
    .busy    (busy)
  );

  // Reference shared decoder, active-low, bit 0 = segment a.
  always_comb begin
    case (dec_val)
      4'h0: dec_seg = 7'b1000000;
      4'h1: dec_seg = 7'b1111001;
      4'h2: dec_seg = 7'b0100100;
      4'h3: dec_seg = 7'b0110000;
      4'h4: dec_seg = 7'b0011001;
      4'h5: dec_seg = 7'b0010010;
      4'h6: dec_seg = 7'b0000010;
      4'h7: dec_seg = 7'b1111000;
      4'h8: dec_seg = 7'b0000000;
      4'h9: dec_seg = 7'b0010000;
      4'hA: dec_seg = 7'b0001000;
      4'hB: dec_seg = 7'b0000011;
      4'hC: dec_seg = 7'b1000110;
      4'hD: dec_seg = 7'b0100001;
      4'hE: dec_seg = 7'b0000110;
      default: dec_seg = 7'b0001110;
    endcase
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  logic [6:0] sweep_seg [N];
  logic       saw_ack;
  int         waited;

  initial begin
    sweep_seg[0] = 7'b1000000;
    sweep_seg[1] = 7'b1111001;
    sweep_seg[2] = 7'b0100100;
    sweep_seg[3] = 7'b0110000;
    sweep_seg[4] = 7'b0011001;
    sweep_seg[5] = 7'b0010010;

    // Reset with random inputs
    resetn = 1'b0;
    req    = N'($urandom);
    nibble = (4*N)'($urandom);
    blank  = N'($urandom);
    repeat (3) @(negedge clock);
    check("rst_hex", hex_out, {(7*N){1'b1}});
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_dec_val", dec_val, 0);

    req = '0; blank = '0; nibble = '0;
    resetn = 1'b1;
    cyc(); cyc();
    check("post_rst_hex", hex_out, {(7*N){1'b1}});
    check("post_rst_ack", ack, 0);

    // Round-robin sweep from pointer 0
    for (int i = 0; i < N; i++) nibble[4*i +: 4] = 4'(i);
    req = '1;
    for (int i = 0; i < N; i++) begin
      cyc();
      check($sformatf("sweep_busy%0d", i), busy, 1);
      check($sformatf("sweep_dec%0d", i), dec_val, i);
      cyc();
      check($sformatf("sweep_ack%0d", i), ack, 64'(1) << i);
      check($sformatf("sweep_hex%0d", i), hex_out[7*i +: 7], sweep_seg[i]);
      req[i] = 1'b0;
    end

    // Single update of slot 2
    nibble[11:8] = 4'h5;
    req[2] = 1'b1;
    cyc();
    check("single_dec", dec_val, 5);
    check("single_busy", busy, 1);
    cyc();
    check("single_ack", ack, 6'b000100);
    check("single_hex", hex_out[20:14], 7'b0010010);
    req[2] = 1'b0;
    cyc();
    check("single_no_2nd_ack", ack, 0);
    check("single_idle", busy, 0);

    // Fairness: pointer is now 3, so slot 4 beats slot 0
    nibble[19:16] = 4'h9;
    nibble[3:0]   = 4'h7;
    req = 6'b010001;
    cyc();
    check("fair_dec_first", dec_val, 9);
    cyc();
    check("fair_ack_first", ack, 6'b010000);
    check("fair_hex4", hex_out[34:28], 7'b0010000);
    req[4] = 1'b0;
    cyc();
    check("fair_dec_second", dec_val, 7);
    check("fair_no_ack_mid", ack, 0);
    cyc();
    check("fair_ack_second", ack, 6'b000001);
    check("fair_hex0", hex_out[6:0], 7'b1111000);
    req[0] = 1'b0;

    // Blanked service
    nibble[7:4] = 4'h8;
    blank[1] = 1'b1;
    req[1] = 1'b1;
    cyc(); cyc();
    check("blank_ack", ack, 6'b000010);
    check("blank_hex", hex_out[13:7], 7'h7F);
    req[1] = 1'b0;
    blank[1] = 1'b0;

    // Idle refresh re-decodes slots without acks
    nibble[3:0] = 4'h0;
    saw_ack = 1'b0;
    for (int c = 0; c < 24; c++) begin
      cyc();
      if (ack != '0) saw_ack = 1'b1;
    end
    check("refresh_hex0", hex_out[6:0], 7'b1000000);
    check("refresh_hex1", hex_out[13:7], 7'b0000000);
    check("refresh_no_ack", saw_ack, 0);

    // Reset during LATCH aborts the write
    nibble[15:12] = 4'h3;
    req[3] = 1'b1;
    waited = 0;
    while (!busy && waited < 20) begin
      cyc();
      waited++;
    end
    check("latch_reached", busy, 1);
    resetn = 1'b0;
    #1;
    check("abort_hex", hex_out, {(7*N){1'b1}});
    check("abort_ack", ack, 0);
    check("abort_busy", busy, 0);
    req = '0;
    @(negedge clock);
    resetn = 1'b1;
    cyc();
    check("abort_no_ack", ack, 0);
    check("abort_hex_after", hex_out, {(7*N){1'b1}});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
